// File: rtl/wb_slave_resp.sv
// wb_slave_resp -- Wishbone B3 responder with a word-addressed internal memory.
//
// Acknowledges classic and incrementing-burst cycles against a 2^MEM_AW-word
// memory. The first beat of a transfer is delayed by cfg_wait wait states;
// subsequent burst beats are acknowledged one per cycle. Addresses above the
// memory range terminate with wb_err instead of wb_ack.
//
// Ports:
//   wb_clk, wb_rst      clock, synchronous active-high reset
//   wb_cyc, wb_stb      bus cycle / transfer strobe from the master
//   wb_we               1 = write, 0 = read
//   wb_sel              byte enables
//   wb_addr             byte address (bits [1:0] ignored)
//   wb_dati             write data
//   wb_cti              cycle type: 000 classic, 010 incrementing, 111 end
//   cfg_wait            wait states before the first ack of a transfer
//   wb_dato             read data, zero unless a read is being acked
//   wb_ack, wb_err      transfer acknowledge / out-of-range error
module wb_slave_resp #(
   parameter int APP_AW = 26,
   parameter int dw     = 32,
   parameter int MEM_AW = 10
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [dw/8-1:0]   wb_sel,
   input  logic [APP_AW-1:0] wb_addr,
   input  logic [dw-1:0]     wb_dati,
   input  logic [2:0]        wb_cti,
   input  logic [3:0]        cfg_wait,
   output logic [dw-1:0]     wb_dato,
   output logic              wb_ack,
   output logic              wb_err
);

   localparam int LANES = dw / 8;
   localparam int DEPTH = 1 << MEM_AW;
   localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

   state_t            state_reg, state_next;
   logic [MEM_AW-1:0] addr_q, addr_next;
   logic [3:0]        wcnt, wcnt_next;
   logic              err_q, err_next;
   logic              ack_int, err_int;
   logic              mem_we;
   logic [dw-1:0]     rd_data;

   logic [MEM_AW-1:0] word_idx;
   logic              out_of_range;
   logic              req;
   logic              cti_incr, cti_end;
   logic              unused_addr_bits;

   assign word_idx         = wb_addr[MEM_AW+1:2];
   assign out_of_range     = |wb_addr[APP_AW-1:MEM_AW+2];
   assign req              = wb_cyc & wb_stb;
   assign cti_incr         = (wb_cti == 3'b010);
   assign cti_end          = (wb_cti == 3'b111);
   assign unused_addr_bits = ^wb_addr[1:0];

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_reg <= IDLE;
         addr_q    <= '0;
         wcnt      <= '0;
         err_q     <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_q    <= addr_next;
         wcnt      <= wcnt_next;
         err_q     <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_q;
      wcnt_next  = wcnt;
      err_next   = err_q;
      ack_int    = 1'b0;
      err_int    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req) begin
               addr_next = word_idx;
               wcnt_next = cfg_wait;
               err_next  = out_of_range;
               if (cfg_wait != 4'd0) state_next = WAIT;
               else                  state_next = ACK;
            end
         end
         WAIT: begin
            wcnt_next = wcnt - 4'd1;
            if (wcnt <= 4'd1) state_next = ACK;
         end
         ACK: begin
            // A master that has already dropped cyc gets neither ack nor write.
            ack_int = ~err_q & wb_cyc;
            err_int = err_q & wb_cyc;
            if (cti_incr && !err_q) begin
               state_next = BURST;
               addr_next  = addr_q + ADDR_ONE;
            end else begin
               state_next = IDLE;
            end
         end
         BURST: begin
            ack_int = req;
            if (req) begin
               addr_next = addr_q + ADDR_ONE;
               if (cti_end) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (!wb_cyc) state_next = IDLE;
   end

   // The transfer in the reset cycle is discarded, so it is not acknowledged.
   assign wb_ack  = ack_int & ~wb_rst;
   assign wb_err  = err_int & ~wb_rst;
   assign mem_we  = wb_ack & wb_we;
   assign wb_dato = (wb_ack && !wb_we) ? rd_data : '0;

   // One memory per byte lane. The read port is registered on addr_next so
   // the word for the coming ack cycle is ready when that cycle starts. A
   // write and a read hit the same word only when a non-burst write ends;
   // the stale read value is never presented because the next ack is at
   // least one IDLE cycle away and the read register reloads in that cycle.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd;

      always_ff @(posedge wb_clk) begin
         if (mem_we && wb_sel[gi]) lane_mem[addr_q] <= wb_dati[8*gi +: 8];
         lane_rd <= lane_mem[addr_next];
      end

      assign rd_data[8*gi +: 8] = lane_rd;
   end

endmodule

// File: tb/tb_wb_slave_resp.sv
// tb_wb_slave_resp -- self-checking bench for wb_slave_resp.
//
// A table of directed classic transfers, hand-written sequences for wait-state
// abort, reset during a burst and a wrapping burst with a strobe gap, then
// randomized classic transfers and bursts checked against a word-array model.
module tb_wb_slave_resp;

   logic        wb_clk;
   logic        wb_rst;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic [25:0] wb_addr;
   logic [31:0] wb_dati;
   logic [2:0]  wb_cti;
   logic [3:0]  cfg_wait;
   logic [31:0] wb_dato;
   logic        wb_ack;
   logic        wb_err;

   int vectors;
   int miscompares;

   // Reference model: one word per location plus a per-byte "written" mask.
   logic [31:0] ref_mem [1024];
   logic [3:0]  ref_bv  [1024];

   logic [31:0] bdat [8];
   logic [3:0]  bsel [8];

   typedef struct {
      bit          we;
      logic [25:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      int          w;
      logic [31:0] exp_dato;
      bit          exp_err;
   } vec_t;

   vec_t tbl [10];

   wb_slave_resp #(.APP_AW(26), .dw(32), .MEM_AW(10)) dut (
      .wb_clk   (wb_clk),
      .wb_rst   (wb_rst),
      .wb_cyc   (wb_cyc),
      .wb_stb   (wb_stb),
      .wb_we    (wb_we),
      .wb_sel   (wb_sel),
      .wb_addr  (wb_addr),
      .wb_dati  (wb_dati),
      .wb_cti   (wb_cti),
      .cfg_wait (cfg_wait),
      .wb_dato  (wb_dato),
      .wb_ack   (wb_ack),
      .wb_err   (wb_err)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
      ref_bv[idx]  = ref_bv[idx] | s;
   endfunction

   // Called at posedge+1; returns at the negedge of the response cycle.
   task automatic wait_resp(output int lat);
      bit got;
      lat = 0;
      got = 0;
      while (!got && lat < 40) begin
         @(negedge wb_clk);
         if (wb_ack || wb_err) got = 1;
         else begin
            @(posedge wb_clk);
            #1;
            lat++;
         end
      end
   endtask

   task automatic run_req(input bit we, input logic [25:0] addr, input logic [31:0] d,
                          input logic [3:0] s, input int w, output logic [31:0] rdat,
                          output int lat, output logic ack, output logic err);
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = we;
      wb_addr  = addr;
      wb_dati  = d;
      wb_sel   = s;
      wb_cti   = 3'b000;
      cfg_wait = w[3:0];
      wait_resp(lat);
      ack  = wb_ack;
      err  = wb_err;
      rdat = wb_dato;
      @(posedge wb_clk);
      #1;
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      @(negedge wb_clk);
      chk("single_cycle_resp", {30'd0, wb_ack, wb_err}, 32'd0);
      $display("txn classic we=%0d addr=%h dati=%h sel=%h wait=%0d -> ack=%0d err=%0d dato=%h lat=%0d",
               we, addr, d, s, w, ack, err, rdat, lat);
   endtask

   // Classic transfer checked against the model.
   task automatic classic(input bit we, input logic [25:0] addr, input logic [31:0] d,
                          input logic [3:0] s, input int w, input bit sync);
      int          a, idx, lat;
      bit          exp_err;
      logic [31:0] rdat;
      logic        ack, err;
      if (sync) begin
         @(posedge wb_clk);
         #1;
      end
      a       = int'(addr);
      exp_err = (a >= 4096);
      idx     = (a / 4) % 1024;
      run_req(we, addr, d, s, w, rdat, lat, ack, err);
      chk("latency", lat, w + 1);
      chk("ack", {31'd0, ack}, {31'd0, !exp_err});
      chk("err", {31'd0, err}, {31'd0, exp_err});
      if (we || exp_err) chk("dato_zero", rdat, 32'd0);
      else if (ref_bv[idx] == 4'hF) chk("read_data", rdat, ref_mem[idx]);
      if (we && !exp_err) model_write(idx, d, s);
   endtask

   // Incrementing burst of n beats from word sidx using bdat/bsel. gap_after=b
   // drops wb_stb for one cycle before beat b (0 = no gap). A classic read of
   // sidx follows with cyc held, proving the responder is back in IDLE.
   task automatic burst(input bit we, input int sidx, input int n, input int w, input int gap_after);
      int lat, idx;
      $display("txn burst we=%0d start=%0d beats=%0d wait=%0d gap=%0d", we, sidx, n, w, gap_after);
      @(posedge wb_clk);
      #1;
      idx      = sidx % 1024;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = we;
      wb_addr  = 26'(idx * 4);
      wb_dati  = bdat[0];
      wb_sel   = bsel[0];
      wb_cti   = 3'b010;
      cfg_wait = w[3:0];
      wait_resp(lat);
      chk("burst_first_latency", lat, w + 1);
      chk("burst_first_ack", {31'd0, wb_ack}, 32'd1);
      if (we) begin
         chk("burst_write_dato", wb_dato, 32'd0);
         model_write(idx, bdat[0], bsel[0]);
      end else if (ref_bv[idx] == 4'hF) chk("burst_read_data", wb_dato, ref_mem[idx]);
      for (int b = 1; b < n; b++) begin
         @(posedge wb_clk);
         #1;
         if (gap_after == b) begin
            wb_stb = 1'b0;
            @(negedge wb_clk);
            chk("burst_gap_ack", {31'd0, wb_ack}, 32'd0);
            @(posedge wb_clk);
            #1;
         end
         idx     = (sidx + b) % 1024;
         wb_stb  = 1'b1;
         wb_addr = 26'(idx * 4);
         wb_dati = bdat[b];
         wb_sel  = bsel[b];
         wb_cti  = (b == n - 1) ? 3'b111 : 3'b010;
         @(negedge wb_clk);
         chk("burst_beat_ack", {31'd0, wb_ack}, 32'd1);
         if (we) begin
            chk("burst_write_dato", wb_dato, 32'd0);
            model_write(idx, bdat[b], bsel[b]);
         end else if (ref_bv[idx] == 4'hF) chk("burst_read_data", wb_dato, ref_mem[idx]);
      end
      @(posedge wb_clk);
      #1;
      classic(1'b0, 26'((sidx % 1024) * 4), 32'd0, 4'hF, w, 1'b0);
   endtask

   initial begin
      int          lat, idx, n, w;
      logic [31:0] rdat;
      logic        ack, err;
      logic [25:0] a;

      vectors     = 0;
      miscompares = 0;
      wb_rst   = 1'b1;
      wb_cyc   = 1'b0;
      wb_stb   = 1'b0;
      wb_we    = 1'b0;
      wb_sel   = 4'h0;
      wb_addr  = '0;
      wb_dati  = '0;
      wb_cti   = 3'b000;
      cfg_wait = 4'd0;
      for (int i = 0; i < 1024; i++) ref_bv[i] = 4'h0;

      //            we    addr          data           sel   w  exp_dato       exp_err
      tbl[0] = '{1'b1, 26'h000_0010, 32'hDEADBEEF, 4'hF, 0, 32'h0000_0000, 1'b0};
      tbl[1] = '{1'b0, 26'h000_0010, 32'h0000_0000, 4'hF, 0, 32'hDEADBEEF, 1'b0};
      tbl[2] = '{1'b0, 26'h000_0010, 32'h0000_0000, 4'hF, 3, 32'hDEADBEEF, 1'b0};
      tbl[3] = '{1'b1, 26'h000_0020, 32'h11223344, 4'hF, 1, 32'h0000_0000, 1'b0};
      tbl[4] = '{1'b1, 26'h000_0020, 32'hAABBCCDD, 4'h5, 0, 32'h0000_0000, 1'b0};
      tbl[5] = '{1'b0, 26'h000_0020, 32'h0000_0000, 4'hF, 2, 32'h11BB33DD, 1'b0};
      tbl[6] = '{1'b1, 26'h000_0000, 32'hCAFEF00D, 4'hF, 0, 32'h0000_0000, 1'b0};
      tbl[7] = '{1'b1, 26'h100_0000, 32'h55555555, 4'hF, 0, 32'h0000_0000, 1'b1};
      tbl[8] = '{1'b0, 26'h100_0000, 32'h0000_0000, 4'hF, 1, 32'h0000_0000, 1'b1};
      tbl[9] = '{1'b0, 26'h000_0000, 32'h0000_0000, 4'hF, 0, 32'hCAFEF00D, 1'b0};

      // Reset state
      repeat (2) @(posedge wb_clk);
      @(negedge wb_clk);
      chk("reset_ack", {31'd0, wb_ack}, 32'd0);
      chk("reset_err", {31'd0, wb_err}, 32'd0);
      chk("reset_dato", wb_dato, 32'd0);
      @(posedge wb_clk);
      #1;
      wb_rst = 1'b0;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         @(posedge wb_clk);
         #1;
         run_req(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sel, tbl[i].w, rdat, lat, ack, err);
         chk("tbl_latency", lat, tbl[i].w + 1);
         chk("tbl_ack", {31'd0, ack}, {31'd0, !tbl[i].exp_err});
         chk("tbl_err", {31'd0, err}, {31'd0, tbl[i].exp_err});
         chk("tbl_dato", rdat, tbl[i].exp_dato);
         if (tbl[i].we && !tbl[i].exp_err)
            model_write((int'(tbl[i].addr) / 4) % 1024, tbl[i].data, tbl[i].sel);
      end

      // Abort during WAIT: cyc dropped with cfg_wait=5, no ack and no write.
      classic(1'b1, 26'h14, 32'h0BADF00D, 4'hF, 0, 1'b1);
      @(posedge wb_clk);
      #1;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = 1'b1;
      wb_addr  = 26'h14;
      wb_dati  = 32'h12345678;
      wb_sel   = 4'hF;
      cfg_wait = 4'd5;
      for (int k = 0; k < 3; k++) begin
         @(negedge wb_clk);
         chk("abort_wait_resp", {30'd0, wb_ack, wb_err}, 32'd0);
         @(posedge wb_clk);
         #1;
      end
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      $display("txn abort word=5 wait=5 cyc dropped in WAIT");
      for (int k = 0; k < 8; k++) begin
         @(negedge wb_clk);
         chk("abort_idle_resp", {30'd0, wb_ack, wb_err}, 32'd0);
         chk("abort_idle_dato", wb_dato, 32'd0);
         @(posedge wb_clk);
      end
      classic(1'b0, 26'h14, 32'd0, 4'hF, 0, 1'b1);

      // Reset during a burst: beat in the reset cycle is neither acked nor written.
      classic(1'b1, 26'(100 * 4), 32'h1111_0000, 4'hF, 0, 1'b1);
      classic(1'b1, 26'(101 * 4), 32'h2222_0000, 4'hF, 0, 1'b1);
      @(posedge wb_clk);
      #1;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = 1'b1;
      wb_addr  = 26'(100 * 4);
      wb_dati  = 32'h0000_00A0;
      wb_sel   = 4'hF;
      wb_cti   = 3'b010;
      cfg_wait = 4'd0;
      @(negedge wb_clk);
      chk("rst_burst_pre_ack", {31'd0, wb_ack}, 32'd0);
      @(posedge wb_clk);
      #1;
      @(negedge wb_clk);
      chk("rst_burst_first_ack", {31'd0, wb_ack}, 32'd1);
      model_write(100, 32'h0000_00A0, 4'hF);
      @(posedge wb_clk);
      #1;
      wb_addr = 26'(101 * 4);
      wb_dati = 32'h0000_00A1;
      wb_rst  = 1'b1;
      @(negedge wb_clk);
      chk("rst_burst_no_resp", {30'd0, wb_ack, wb_err}, 32'd0);
      @(posedge wb_clk);
      #1;
      wb_rst = 1'b0;
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      wb_cti = 3'b000;
      $display("txn reset asserted during burst at word 101");
      @(negedge wb_clk);
      chk("rst_after_resp", {30'd0, wb_ack, wb_err}, 32'd0);
      chk("rst_after_dato", wb_dato, 32'd0);
      classic(1'b0, 26'(101 * 4), 32'd0, 4'hF, 0, 1'b1);
      classic(1'b0, 26'(100 * 4), 32'd0, 4'hF, 0, 1'b1);

      // Wrapping write burst with a strobe gap after beat 2.
      for (int b = 0; b < 4; b++) begin
         bdat[b] = 32'(b + 1);
         bsel[b] = 4'hF;
      end
      burst(1'b1, 1022, 4, 2, 2);
      classic(1'b0, 26'(1022 * 4), 32'd0, 4'hF, 0, 1'b1);
      classic(1'b0, 26'(1023 * 4), 32'd0, 4'hF, 0, 1'b1);
      classic(1'b0, 26'(0 * 4),    32'd0, 4'hF, 0, 1'b1);
      classic(1'b0, 26'(1 * 4),    32'd0, 4'hF, 0, 1'b1);

      // Random: preload, classic transfers, bursts.
      for (int i = 200; i < 216; i++) classic(1'b1, 26'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), 1'b1);
      for (int i = 300; i < 320; i++) classic(1'b1, 26'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), 1'b1);
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 7) == 0) a = 26'($urandom_range(4096, 32'h03FF_FFFF));
         else a = 26'((200 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3));
         classic(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4), 1'b1);
      end
      for (int t = 0; t < 6; t++) begin
         n   = $urandom_range(2, 5);
         idx = 300 + $urandom_range(0, 14);
         w   = $urandom_range(0, 3);
         for (int b = 0; b < 8; b++) begin
            bdat[b] = $urandom;
            bsel[b] = 4'($urandom_range(0, 15));
         end
         burst(1'($urandom_range(0, 1)), idx, n, w, $urandom_range(0, n - 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
